// File: rtl/commit_rat.sv
// Committed register alias table: applies up to WIDTH in-order commits per cycle and returns displaced tags.
// Optional retire/free performance counters are enabled with `define COMMIT_RAT_PERF_EN.
module commit_rat #(
  parameter int WIDTH     = 4,
  parameter int RD_PORTS  = 4,
  parameter int NUM_AREGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      IN_comValid,
  input  logic [WIDTH*5-1:0]    IN_comNmDst,
  input  logic [WIDTH*7-1:0]    IN_comTagDst,
  input  logic [WIDTH*7-1:0]    IN_comSqN,
  input  logic                  IN_mispredFlush,
  input  logic [RD_PORTS*5-1:0] IN_rdNm,
  output logic [RD_PORTS*7-1:0] OUT_rdTag,
  output logic [WIDTH-1:0]      OUT_freeValid,
  output logic [WIDTH*7-1:0]    OUT_freeTag,
  output logic [6:0]            OUT_lastSqN,
`ifdef COMMIT_RAT_PERF_EN
  output logic [63:0]           OUT_perfRetired,
  output logic [63:0]           OUT_perfFreed,
`endif
  output logic [2:0]            OUT_retireCnt
);

  localparam logic [6:0] NO_TAG = 7'h40;

  logic [6:0]         map [NUM_AREGS];
  logic [6:0]         run [NUM_AREGS];
  logic [WIDTH-1:0]   com_p0;
  logic [WIDTH-1:0]   vld_p0;
  logic [WIDTH*7-1:0] free_tag_p0;
  logic [2:0]         cnt_p0;
  logic [6:0]         sqn_p0;
  logic [4:0]         nm;
  logic [6:0]         tag;
  logic [6:0]         old;

  logic [WIDTH-1:0]   vld_p1;
  logic [WIDTH*7-1:0] free_tag_p1;
  logic [2:0]         cnt_p1;
  logic [6:0]         sqn_p1;

  assign com_p0 = IN_comValid & {WIDTH{~IN_mispredFlush}};

  // Stage p0: walk lanes oldest-first on a running copy so younger lanes see older writes.
  always_comb begin
    run         = map;
    vld_p0      = '0;
    free_tag_p0 = '0;
    cnt_p0      = '0;
    sqn_p0      = sqn_p1;
    nm          = '0;
    tag         = '0;
    old         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nm  = IN_comNmDst[i*5 +: 5];
      tag = IN_comTagDst[i*7 +: 7];
      if (com_p0[i]) begin
        cnt_p0 = cnt_p0 + 3'd1;
        sqn_p0 = IN_comSqN[i*7 +: 7];
        if (nm != 5'd0) begin
          old     = run[nm];
          run[nm] = tag;
          if (!old[6]) begin
            vld_p0[i]             = 1'b1;
            free_tag_p0[i*7 +: 7] = old;
          end
        end else if (!tag[6]) begin
          // Allocated tag with no architectural home goes straight back.
          vld_p0[i]             = 1'b1;
          free_tag_p0[i*7 +: 7] = tag;
        end
      end
    end
  end

  // Stage p1: committed state and registered free/retire outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_AREGS; r++) map[r] <= NO_TAG;
      vld_p1      <= '0;
      free_tag_p1 <= '0;
      cnt_p1      <= '0;
      sqn_p1      <= '0;
    end else begin
      map         <= run;
      vld_p1      <= vld_p0;
      free_tag_p1 <= free_tag_p0;
      cnt_p1      <= cnt_p0;
      sqn_p1      <= sqn_p0;
    end
  end

`ifdef COMMIT_RAT_PERF_EN
  function automatic logic [63:0] popcnt(input logic [WIDTH-1:0] v);
    logic [63:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) c = c + {63'd0, v[k]};
    return c;
  endfunction

  logic [63:0] perf_ret_p1;
  logic [63:0] perf_free_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ret_p1  <= '0;
      perf_free_p1 <= '0;
    end else begin
      perf_ret_p1  <= perf_ret_p1 + {61'd0, cnt_p0};
      perf_free_p1 <= perf_free_p1 + popcnt(vld_p0);
    end
  end

  assign OUT_perfRetired = perf_ret_p1;
  assign OUT_perfFreed   = perf_free_p1;
`endif

  always_comb begin
    OUT_rdTag = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      OUT_rdTag[p*7 +: 7] = (IN_rdNm[p*5 +: 5] == 5'd0) ? NO_TAG : map[IN_rdNm[p*5 +: 5]];
    end
  end

  assign OUT_freeValid = vld_p1;
  assign OUT_freeTag   = free_tag_p1;
  assign OUT_lastSqN   = sqn_p1;
  assign OUT_retireCnt = cnt_p1;

endmodule

// File: doc/commit_rat.md
Name: commit_rat

Overview:
- Committed register alias table; sits directly downstream of the reorder buffer's commit port.
- Consumes up to WIDTH committed uops per cycle in program order.
- Maintains the architectural-register → physical-tag map.
- Returns the displaced physical tags to the free-tag list.
- Exposes read ports so rename can restore its speculative map from committed state after a flush.

Parameters:
- WIDTH, 4, commit lanes per cycle; lane 0 is oldest.
- RD_PORTS, 4, committed-map read ports.
- NUM_AREGS, 32, architectural registers; index width is 5 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_comValid  in  WIDTH  lane i carries a committed uop
- IN_comNmDst  in  WIDTH*5  architectural destination per lane; 0 = no destination
- IN_comTagDst  in  WIDTH*7  physical tag per lane; bit6 set = no physical register
- IN_comSqN  in  WIDTH*7  sequence number per lane
- IN_mispredFlush  in  1  reorder buffer is replaying the surviving speculative stream; not commits
- IN_rdNm  in  RD_PORTS*5  read-port register index
- OUT_rdTag  out  RD_PORTS*7  committed tag for IN_rdNm; combinational from map registers
- OUT_freeValid  out  WIDTH  freed-tag valid per lane
- OUT_freeTag  out  WIDTH*7  freed tag per lane
- OUT_lastSqN  out  7  sequence number of the youngest uop committed so far
- OUT_retireCnt  out  3  number of uops committed in the previous cycle

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - map[r] = 7'h40 for every r (architectural zero, no physical register).
  - OUT_freeValid = 0, OUT_freeTag = 0.
  - OUT_lastSqN = 0, OUT_retireCnt = 0.
  - Reset dominates every other input in that cycle.
- Commit condition: lane i commits when IN_comValid[i] && !IN_mispredFlush. While IN_mispredFlush = 1:
  - map is unchanged;
  - OUT_freeValid = 0 next cycle;
  - OUT_retireCnt = 0 next cycle;
  - OUT_lastSqN holds.
- Lanes are processed strictly in order 0..WIDTH-1. A running map copy carries lane i's update into lane i+1 within the same cycle.
- Committing lane with nmDst != 0:
  - old = running map[nmDst]; running map[nmDst] = tagDst.
  - Free old if old[6] = 0.
- Committing lane with nmDst == 0:
  - map is unchanged.
  - Free tagDst itself if tagDst[6] = 0 (an allocated tag with no architectural home).
- Same nmDst in several lanes of one cycle:
  - the youngest lane's tag ends up in map;
  - each older lane's tag is freed by the next younger lane writing that register.
- Free outputs:
  - registered; latency is 1 cycle from the commit edge;
  - OUT_freeTag lane i corresponds to commit lane i;
  - OUT_freeTag is 0 where OUT_freeValid[i] = 0.
- Non-contiguous valid lanes (e.g. 4'b0101) are legal; each valid lane is processed independently in lane order.
- OUT_lastSqN is updated to the comSqN of the highest-index committing lane.
- OUT_retireCnt = popcount of committing lanes.
- OUT_rdTag:
  - reflects map writes committed at earlier edges only; no same-cycle bypass;
  - IN_rdNm = 0 always returns 7'h40.
- The block never stalls the reorder buffer; there is no backpressure input. The free list must accept WIDTH tags per cycle.

Optional Feature:
- Macro COMMIT_RAT_PERF_EN.
- When defined, adds:
  - output OUT_perfRetired (64 bit): count of committed uops;
  - output OUT_perfFreed (64 bit): count of freed tags.
- Both counters reset to 0, wrap modulo 2^64, and add per-cycle counts at the same edge as the free outputs.
- Both counters freeze while IN_mispredFlush = 1.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read all 32 regs via rd ports → every OUT_rdTag = 7'h40; OUT_freeValid = 0.
- Lane0 commit nmDst=5, tag=7'h03 → next cycle freeValid = 0 (old 7'h40 not freed); then rdNm=5 → 7'h03. Then commit nmDst=5, tag=7'h09 → freeValid[0] = 1, freeTag[0] = 7'h03.
- Same cycle: lanes 0..3 all nmDst=7 with tags 1, 2, 3, 4 → freeValid = 4'b1110, freeTag lanes 1..3 = 1, 2, 3; map[7] = 4; retireCnt = 4.
- IN_mispredFlush = 1 with valid = 4'b1111 and nmDst=3, tag=7'h11 → map[3] unchanged, freeValid = 0, retireCnt = 0, lastSqN unchanged.
- Lane2 only, nmDst=0, tag=7'h22, sqN=7'h45 → freeValid = 4'b0100, freeTag[2] = 7'h22, lastSqN = 7'h45; a repeat with tag=7'h62 → no free.
- rst asserted in the same cycle as a 4-lane commit → all outputs at reset values, map all 7'h40.
